per4_farm: RTL and testbench
============================

# per4_farm

Four-worker farm that multiplies two N-bit input streams by 4. One operand pair is accepted every clock. An emitter deals each pair round-robin to one of four identical multi-cycle workers. A collector drains the workers in the same order, so results leave in input order at one pair per clock. Used as a throughput-parallelism example block between a free-running stimulus source and a result sink.

## Interface
- N, default 8: width of every operand and result.
- Worker count is fixed at 4 and is not a parameter.
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- res1, output, N: 4 × operand from num1, registered.
- res2, output, N: 4 × operand from num2, registered.
- num1, input, N: operand stream 1, sampled every rising edge.
- num2, input, N: operand stream 2, sampled every rising edge.
- Port order: res1, res2, num1, num2, clk, rst.
- There is no handshake and no valid signal: inputs are consumed every cycle and outputs update every cycle.

## Operation
- Emitter: a 2-bit dispatch pointer `dp`.
  - Each non-reset edge loads {num1, num2} into worker `dp`.
  - `dp` then increments, wrapping 3 → 0.
- Worker k: holds two N-bit accumulators (a1, a2) and a 2-bit phase.
  - Phase LOAD, at the edge where the worker is selected: acc ← operand; phase ← SH1.
  - Phase SH1, next edge: acc ← acc << 1, dropping the MSB; phase ← SH2.
  - Phase SH2, next edge: acc ← acc << 1, dropping the MSB; phase ← DONE.
  - Phase DONE: acc holds its value until the worker is selected again, which happens exactly 4 edges after LOAD.
  - A worker is never selected while busy; round-robin guarantees this.
- Collector: a 2-bit pointer `cp` that trails `dp` by 3 (mod 4).
  - Each edge: res1 ← a1 of worker `cp`, res2 ← a2 of worker `cp`.
  - `cp` then increments.
  - The collector reads a worker in its DONE phase, i.e. after both shifts.
- Arithmetic: result = (operand × 4) mod 2^N. The two MSBs of the operand are discarded. The two streams are fully independent.

## Timing
- Operand pair sampled at edge t appears on res1/res2 immediately after edge t+3: latency 3 cycles.
- Throughput: 1 pair per cycle, sustained indefinitely.
- Reset (rst=1 at an edge) clears:
  - dp ← 0 and cp ← 1, so cp trails dp by 3;
  - every accumulator ← 0 and every phase ← DONE;
  - res1, res2 ← 0.
- During reset, inputs are ignored.
- First sample after reset: taken at the first edge with rst=0 (edge t0). Outputs stay 0 through edge t0+2 and show the t0 result after edge t0+3.
- Reset asserted mid-operation discards every in-flight result. No partial result ever appears on the outputs.
- Operands held constant for several cycles produce the same result on consecutive cycles.

## Configuration
- PER4_FARM_SATURATE_EN.
  - Defined: each shift saturates. If an accumulator's MSB is 1 before a shift, it becomes all-ones, and the final result is min(operand × 4, 2^N − 1).
  - Undefined (default): modulo-2^N wrap as described above.
- The macro affects both streams identically. Latency is unchanged either way.

## Test plan
- Reset then steady input: rst for 2 edges, then num1=3, num2=4 held → res1=12, res2=16 from the 3rd edge after release; both 0 before that.
- Back-to-back stream: num1 = 1, 2, 3, 4, 5, 6 on consecutive edges, num2 = num1+1 → res1 = 4, 8, 12, 16, 20, 24 and res2 = 8, 12, 16, 20, 24, 28 on consecutive cycles starting 3 cycles later, in order, with no gaps.
- Slow stream, changing every 4 cycles: num1 = 0, 2, 4, 6, 8 with num2 = num1+1 → res1 = 0, 8, 16, 24, 32 and res2 = 4, 12, 20, 28, 36, each held 4 cycles, delayed 3 cycles.
- Overflow: num1=8'h50, num2=8'hFF → default: res1=8'h40, res2=8'hFC; with PER4_FARM_SATURATE_EN: res1=8'hFF, res2=8'hFF.
- Reset mid-flight: feed 10, 11, 12 on consecutive edges, assert rst on the next edge, then feed 7 → res1 shows 0 after the reset edge; 40, 44 and 48 never appear; 28 appears 3 cycles after 7 is sampled.

Source files
------------

// File: rtl/per4_farm.sv
// per4_farm: four-worker farm computing 4 x operand on two independent N-bit
// streams. An emitter deals each operand pair round-robin to one of four
// multi-cycle shift workers. A collector drains them in the same order, so
// results leave in input order at one pair per clock with 3 cycles latency.
//
// Ports:
//   res1, res2 : out, N  registered results (4 x num1, 4 x num2)
//   num1, num2 : in,  N  operand streams, sampled every rising edge
//   clk        : in      clock
//   rst        : in      synchronous active-high reset
//
// Config macro: PER4_FARM_SATURATE_EN
//   defined   -> each shift saturates to all-ones, result = min(4*op, 2^N-1)
//   undefined -> result = (4*op) mod 2^N

// One worker: load on select, shift twice, then hold until reselected.
module per4_worker #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  output logic [N-1:0] a1,
  output logic [N-1:0] a2
);
  // LOAD is the select edge itself; it is never held in the phase register.
  typedef enum logic [1:0] {LOAD, SH1, SH2, DONE} phase_t;

  phase_t       ph, ph_nx;
  logic [N-1:0] a1_nx, a2_nx;

  function automatic logic [N-1:0] shl(input logic [N-1:0] x);
`ifdef PER4_FARM_SATURATE_EN
    // An MSB of 1 would be lost by the shift: clamp instead.
    return x[N-1] ? '1 : {x[N-2:0], 1'b0};
`else
    return {x[N-2:0], 1'b0};
`endif
  endfunction

  always_comb begin
    ph_nx = ph;
    a1_nx = a1;
    a2_nx = a2;
    if (sel) begin
      a1_nx = op1;
      a2_nx = op2;
      ph_nx = SH1;
    end else begin
      case (ph)
        SH1: begin
          a1_nx = shl(a1);
          a2_nx = shl(a2);
          ph_nx = SH2;
        end
        SH2: begin
          a1_nx = shl(a1);
          a2_nx = shl(a2);
          ph_nx = DONE;
        end
        default: ph_nx = ph;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= DONE;
      a1 <= '0;
      a2 <= '0;
    end else begin
      ph <= ph_nx;
      a1 <= a1_nx;
      a2 <= a2_nx;
    end
  end
endmodule

module per4_farm #(
  parameter int N = 8
) (
  output logic [N-1:0] res1,
  output logic [N-1:0] res2,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic         clk,
  input  logic         rst
);
  logic [1:0]          dp, cp;
  logic [3:0][N-1:0]   wa1, wa2;

  for (genvar k = 0; k < 4; k++) begin : g_w
    per4_worker #(.N(N)) u_w (
      .clk (clk),
      .rst (rst),
      .sel (dp == 2'(k)),
      .op1 (num1),
      .op2 (num2),
      .a1  (wa1[k]),
      .a2  (wa2[k])
    );
  end

  // cp = dp - 3 (mod 4): the collector reaches a worker on the edge after its
  // second shift, which is exactly when that worker is in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp   <= 2'd0;
      cp   <= 2'd1;
      res1 <= '0;
      res2 <= '0;
    end else begin
      dp   <= dp + 2'd1;
      cp   <= cp + 2'd1;
      res1 <= wa1[cp];
      res2 <= wa2[cp];
    end
  end
endmodule

// File: tb/tb_per4_farm.sv
// Self-checking bench for per4_farm: a 3-deep expectation queue models the
// pipeline; every edge pushes the reference result of the sampled operands and
// pops the value the outputs must show after that edge. Reset refills the
// queue with zeros so in-flight results are expected to vanish.
module tb_per4_farm;
  localparam int N = 8;

  logic [N-1:0] res1, res2, num1, num2;
  logic         clk, rst;

  int total = 0;
  int bad   = 0;

  logic [2*N-1:0] q[$];

  per4_farm #(.N(N)) dut (
    .res1 (res1),
    .res2 (res2),
    .num1 (num1),
    .num2 (num2),
    .clk  (clk),
    .rst  (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref4(input logic [N-1:0] x);
    int v;
    v = int'(x) * 4;
`ifdef PER4_FARM_SATURATE_EN
    if (v > (1 << N) - 1) v = (1 << N) - 1;
`endif
    return N'(v);
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, update the model, and check both outputs.
  task automatic step(input logic [N-1:0] n1, input logic [N-1:0] n2, input logic r);
    logic [2*N-1:0] e;
    @(negedge clk);
    num1 = n1;
    num2 = n2;
    rst  = r;
    @(posedge clk);
    if (r) begin
      q = {};
      q.push_back('0);
      q.push_back('0);
      q.push_back('0);
      e = '0;
    end else begin
      q.push_back({ref4(n1), ref4(n2)});
      e = q.pop_front();
    end
    #1;
    chk("res1", res1, e[2*N-1:N]);
    chk("res2", res2, e[N-1:0]);
  endtask

  initial begin
    num1 = '0;
    num2 = '0;
    rst  = 1'b1;

    // reset, then steady 3/4
    step(8'd0, 8'd0, 1'b1);
    step(8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(8'd3, 8'd4, 1'b0);
    chk("steady_res1", res1, 8'd12);
    chk("steady_res2", res2, 8'd16);

    // back-to-back stream
    for (int i = 1; i <= 6; i++) step(N'(i), N'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0);

    // slow stream, each value held 4 cycles
    for (int v = 0; v <= 8; v += 2)
      for (int j = 0; j < 4; j++) step(N'(v), N'(v + 1), 1'b0);

    // overflow
    for (int i = 0; i < 5; i++) step(8'h50, 8'hFF, 1'b0);
`ifdef PER4_FARM_SATURATE_EN
    chk("ovf_res1", res1, 8'hFF);
    chk("ovf_res2", res2, 8'hFF);
`else
    chk("ovf_res1", res1, 8'h40);
    chk("ovf_res2", res2, 8'hFC);
`endif

    // boundary values
    step(8'h3F, 8'h40, 1'b0);
    step(8'h7F, 8'h80, 1'b0);
    step(8'hC0, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0);

    // reset mid-flight: 10,11,12 in flight, rst (inputs ignored), then 7
    step(8'd10, 8'd10, 1'b0);
    step(8'd11, 8'd11, 1'b0);
    step(8'd12, 8'd12, 1'b0);
    step(8'd99, 8'd99, 1'b1);
    chk("rst_mid_res1", res1, 8'd0);
    step(8'd7, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0);
    chk("after_rst_res1", res1, 8'd28);
    chk("after_rst_res2", res2, 8'd28);

    // random independent streams
    for (int i = 0; i < 40; i++)
      step(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 3; i++) step(8'd0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
